// File: rtl/rx_frame_pkg.sv
// Shared constants, state encoding and frame checker for the receive frame
// synchroniser.
package rx_frame_pkg;

  localparam int         FRAME_BITS     = 40;
  localparam int         PAYLOAD_BITS   = 24;
  localparam logic [7:0] DEFAULT_HEADER = 8'hCC;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Header match plus 8-bit wrap-around sum of header and payload bytes.
  function automatic logic frame_check(input logic [FRAME_BITS-1:0] w,
                                       input logic [7:0] hdr);
    logic [7:0] sum;
    sum = w[39:32] + w[31:24] + w[23:16] + w[15:8];
    return (w[39:32] == hdr) && (sum == w[7:0]);
  endfunction

endpackage

// File: rtl/rx_frame_fifo2.sv
// Two-entry valid/ready output buffer; a push into a full buffer with no
// simultaneous pop is dropped and flagged for one cycle.
module rx_frame_fifo2 #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  logic [DATA_W-1:0] head, tail;
  logic [1:0]        count;
  logic              pop, full, accept;

  always_comb begin
    pop    = out_ready & (count != 2'd0);
    full   = (count == 2'd2);
    accept = push & (!full | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & !pop;
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = head;
  assign out_valid = (count != 2'd0);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame synchroniser: hunts for header/checksum-valid 40-bit frames, confirms
// alignment, holds lock through isolated errors and buffers validated payloads.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [7:0] HEADER    = DEFAULT_HEADER,
  parameter int         CONFIRM_N = 2,
  parameter int         LOSS_N    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ser_i,
  input  logic                    sync_flag,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    lock_o,
  output logic [1:0]              state_o,
  output logic                    frame_err_o,
  output logic                    overflow_o
);

  localparam logic [3:0] CONFIRM_C = 4'(CONFIRM_N);
  localparam logic [3:0] LOSS_C    = 4'(LOSS_N);
  localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);

  state_t                  state, state_nx;
  logic [FRAME_BITS-1:0]   win_p0, win_nx;
  logic [5:0]              bit_cnt, base_cnt, bit_cnt_nx;
  logic [3:0]              good_cnt, bad_cnt, good_cnt_nx, bad_cnt_nx;
  logic [3:0]              good_inc, bad_inc;
  logic                    qualify, push, frame_err_nx;
  logic                    vld_p1, ok_p1;
  logic [PAYLOAD_BITS-1:0] payload_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Stage 0: shift window; a shift qualifies against the post-eval state and
  // alignment so a decision and a shift in the same cycle stay consistent.
  always_comb begin
    win_nx  = (win_p0 << 1) | {{(FRAME_BITS-1){1'b0}}, ser_i};
    qualify = sync_flag & ((state_nx == HUNT) | (base_cnt == LAST_BIT));
    if (!sync_flag)                bit_cnt_nx = base_cnt;
    else if (base_cnt == LAST_BIT) bit_cnt_nx = 6'd0;
    else                           bit_cnt_nx = base_cnt + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_p0      <= '0;
      bit_cnt     <= 6'd0;
      good_cnt    <= 4'd0;
      bad_cnt     <= 4'd0;
      vld_p1      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (sync_flag) win_p0 <= win_nx;
      bit_cnt     <= bit_cnt_nx;
      good_cnt    <= good_cnt_nx;
      bad_cnt     <= bad_cnt_nx;
      vld_p1      <= qualify;
      frame_err_o <= frame_err_nx;
    end
  end

  // Stage 1: snapshot of the evaluated window, immune to a shift during eval
  always_ff @(posedge clk) begin
    if (qualify) begin
      ok_p1      <= frame_check(win_nx, HEADER);
      payload_p1 <= win_nx[PAYLOAD_BITS+7:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_nx;
  end

  always_comb begin
    good_inc     = sat_inc(good_cnt);
    bad_inc      = sat_inc(bad_cnt);
    state_nx     = state;
    good_cnt_nx  = good_cnt;
    bad_cnt_nx   = bad_cnt;
    base_cnt     = bit_cnt;
    push         = 1'b0;
    frame_err_nx = 1'b0;
    if (vld_p1) begin
      case (state)
        HUNT: begin
          if (ok_p1) begin
            base_cnt    = 6'd0;
            good_cnt_nx = 4'd1;
            bad_cnt_nx  = 4'd0;
            if (CONFIRM_C <= 4'd1) begin
              state_nx = LOCKED;
              push     = 1'b1;
            end else begin
              state_nx = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (ok_p1) begin
            good_cnt_nx = good_inc;
            if (good_inc >= CONFIRM_C) begin
              state_nx   = LOCKED;
              push       = 1'b1;
              bad_cnt_nx = 4'd0;
            end
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = HUNT;
          end
        end
        LOCKED: begin
          if (ok_p1) begin
            push       = 1'b1;
            bad_cnt_nx = 4'd0;
          end else begin
            frame_err_nx = 1'b1;
            bad_cnt_nx   = bad_inc;
            if (bad_inc >= LOSS_C) state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  always_comb begin
    lock_o  = (state == LOCKED);
    state_o = state;
  end

  rx_frame_fifo2 #(.DATA_W(PAYLOAD_BITS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (payload_p1),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow_o)
  );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: stimulus queues expected payloads, a
// monitor checks every accepted output word; control outputs checked inline.
module tb_rx_frame_ctrl;

  localparam logic [39:0] GOOD = 40'hCC12345668;
  localparam logic [39:0] BAD  = 40'hCC12345669;
  localparam logic [39:0] F_A  = 40'hCC11223332;
  localparam logic [39:0] F_B  = 40'hCC010203D2;
  localparam logic [39:0] F_C  = 40'hCC0000FFCB;
  localparam logic [39:0] F_D  = 40'hCC0A0B0CED;

  logic        clk = 1'b0;
  logic        rst, ser_i, sync_flag, out_ready;
  logic [23:0] out_data;
  logic        out_valid, lock_o, frame_err_o, overflow_o;
  logic [1:0]  state_o;

  int          n_tests = 0;
  int          n_fails = 0;
  logic [23:0] exp_q[$];

  rx_frame_ctrl #(.HEADER(8'hCC), .CONFIRM_N(2), .LOSS_N(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ser_i       (ser_i),
    .sync_flag   (sync_flag),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lock_o      (lock_o),
    .state_o     (state_o),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ctrl(input string name, input logic [1:0] st, input logic err,
                            input logic ovf);
    check({name, "/state"}, 24'(state_o), 24'(st));
    check({name, "/lock"}, 24'(lock_o), 24'(st == 2'd2));
    check({name, "/err"}, 24'(frame_err_o), 24'(err));
    check({name, "/ovf"}, 24'(overflow_o), 24'(ovf));
  endtask

  task automatic check_reset(input string name);
    check_ctrl(name, 2'd0, 1'b0, 1'b0);
    check({name, "/valid"}, 24'(out_valid), 24'd0);
    check({name, "/data"}, out_data, 24'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    ser_i     = b;
    sync_flag = 1'b1;
    tick();
    sync_flag = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_range(input logic [39:0] f, input int hi, input int lo, input int gap);
    for (int i = hi; i >= lo; i--) send_bit(f[i], gap);
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap);
    send_range(f, 39, 0, gap);
  endtask

  // Monitor: every word the consumer accepts must be the next expected one
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fails++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] pre;
    pre       = 13'b1011011101101;
    rst       = 1'b1;
    ser_i     = 1'b0;
    sync_flag = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;

    // Acquisition with CONFIRM_N=2
    send_frame(GOOD, 0); tick();
    check_ctrl("acq1", 2'd1, 1'b0, 1'b0);
    check("acq1/valid", 24'(out_valid), 24'd0);
    exp_q.push_back(24'h123456);
    send_frame(GOOD, 0); tick();
    check_ctrl("acq2", 2'd2, 1'b0, 1'b0);
    exp_q.push_back(24'h123456);
    send_frame(GOOD, 0); tick();
    check_ctrl("acq3", 2'd2, 1'b0, 1'b0);

    // Isolated error, then loss of lock after three consecutive bad frames
    send_frame(BAD, 0); tick();
    check_ctrl("bad1", 2'd2, 1'b1, 1'b0);
    tick();
    check("bad1_pulse", 24'(frame_err_o), 24'd0);
    exp_q.push_back(24'h123456);
    send_frame(GOOD, 0); tick();
    check_ctrl("recover", 2'd2, 1'b0, 1'b0);
    send_frame(BAD, 0); tick();
    check_ctrl("loss1", 2'd2, 1'b1, 1'b0);
    send_frame(BAD, 0); tick();
    check_ctrl("loss2", 2'd2, 1'b1, 1'b0);
    send_frame(BAD, 0); tick();
    check_ctrl("loss3", 2'd0, 1'b1, 1'b0);
    send_frame(GOOD, 0); tick();
    check_ctrl("reacq", 2'd1, 1'b0, 1'b0);

    // Arbitrary offset, sparse strobe, exact 40-bit boundary in VERIFY
    rst = 1'b1; tick(); tick();
    check_reset("reset2");
    rst = 1'b0;
    send_range(40'(pre), 12, 0, 3);
    check_ctrl("prefix", 2'd0, 1'b0, 1'b0);
    send_frame(GOOD, 3);
    check_ctrl("off_acq", 2'd1, 1'b0, 1'b0);
    exp_q.push_back(24'h112233);
    send_range(F_A, 39, 1, 3);
    check_ctrl("boundary39", 2'd1, 1'b0, 1'b0);
    send_bit(F_A[0], 3);
    check_ctrl("boundary40", 2'd2, 1'b0, 1'b0);

    // Back-pressure: two held, third dropped; push+pop while full
    out_ready = 1'b0;
    exp_q.push_back(24'h112233);
    send_frame(F_A, 0); tick();
    exp_q.push_back(24'h010203);
    send_frame(F_B, 0); tick();
    check("held/valid", 24'(out_valid), 24'd1);
    check("held/head", out_data, 24'h112233);
    send_frame(F_C, 0); tick();
    check_ctrl("ovf", 2'd2, 1'b0, 1'b1);
    tick();
    check("ovf_pulse", 24'(overflow_o), 24'd0);
    check("head_stable", out_data, 24'h112233);
    exp_q.push_back(24'h0A0B0C);
    send_frame(F_D, 0);
    out_ready = 1'b1;
    tick();
    check_ctrl("push_pop_full", 2'd2, 1'b0, 1'b0);
    repeat (4) tick();
    check("drained/queue", 24'(exp_q.size()), 24'd0);
    check("drained/valid", 24'(out_valid), 24'd0);

    // Reset while LOCKED, buffer full and an evaluation pending
    out_ready = 1'b0;
    send_frame(GOOD, 0); tick();
    send_frame(GOOD, 0); tick();
    send_frame(GOOD, 0);
    rst = 1'b1;
    tick();
    check_reset("rst_mid");
    rst = 1'b0;
    tick();
    check_reset("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
